axi4_addr_issue: RTL and testbench

AXI4_ADDR_ISSUE -- requirements
Module: axi4_addr_issue

---
 rtl/axi4_addr_issue_pkg.sv | 41 ++++
 rtl/axi4_addr_issue_if.sv | 47 ++++
 rtl/burst_len_calc.sv | 46 ++++
 rtl/axi4_addr_issue.sv | 121 ++++++++++++
 tb/tb_axi4_addr_issue.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_addr_issue_pkg.sv
// -----------------------------------------------------------------------------
// axi4_addr_issue_pkg
// Shared AXI4 definitions for the address-issue block: the default address
// width define, the issue FSM state encoding, the AXI4 BURST encodings and the
// 4 KB boundary / maximum-burst constants, plus a size-clamp helper.
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif

package axi4_addr_issue_pkg;

  // Issue FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } issue_state_t;

  // AXI4 AxBURST encodings.
  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_t;

  // A burst may never cross this byte boundary.
  localparam int unsigned BOUNDARY_4K     = 4096;
  // AXI4 INCR bursts carry at most this many beats.
  localparam int unsigned MAX_BURST_BEATS = 256;

  // Requests asking for a wider beat than the data bus supports are narrowed
  // to the bus width.
  function automatic logic [2:0] clamp_size(input logic [2:0] size,
                                            input logic [2:0] max_size);
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/axi4_addr_issue_if.sv
// -----------------------------------------------------------------------------
// axi4_addr_issue_if
// Bundles the request handshake, the AXI4 address-channel fields and the
// status outputs of axi4_addr_issue.
//   slave  : the address-issue block (consumes requests, drives AXI4 Ax*)
//   master : the requester / AXI4 slave side (drives requests and axready_i)
// Signals: req_addr_i, req_beats_i, req_size_i, req_valid_i / req_ready_o,
//          axaddr_o, axlen_o, axsize_o, axburst_o, axvalid_o / axready_i,
//          busy_o, done_o.
// -----------------------------------------------------------------------------
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif

interface axi4_addr_issue_if #(
  parameter int ADDR_WIDTH = `AXI4_ADDR_WIDTH,
  parameter int CNT_WIDTH  = 16
);
  // Request side
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [CNT_WIDTH-1:0]  req_beats_i;
  logic [2:0]            req_size_i;
  logic                  req_valid_i;
  logic                  req_ready_o;
  // AXI4 address channel
  logic [ADDR_WIDTH-1:0] axaddr_o;
  logic [7:0]            axlen_o;
  logic [2:0]            axsize_o;
  logic [1:0]            axburst_o;
  logic                  axvalid_o;
  logic                  axready_i;
  // Status
  logic                  busy_o;
  logic                  done_o;

  modport slave (
    input  req_addr_i, req_beats_i, req_size_i, req_valid_i, axready_i,
    output req_ready_o, axaddr_o, axlen_o, axsize_o, axburst_o, axvalid_o,
           busy_o, done_o
  );

  modport master (
    output req_addr_i, req_beats_i, req_size_i, req_valid_i, axready_i,
    input  req_ready_o, axaddr_o, axlen_o, axsize_o, axburst_o, axvalid_o,
           busy_o, done_o
  );
endinterface

// File: rtl/burst_len_calc.sv
// -----------------------------------------------------------------------------
// burst_len_calc
// Purely combinational: number of beats for the next burst,
//   burst_beats = min(remaining, 256, beats_to_4k)
// where beats_to_4k counts the beats from the size-aligned current address
// up to the next 4 KB boundary.
// Ports:
//   addr_lo     in  12         low 12 bits of the current address
//   size        in  3          log2 bytes per beat (already clamped)
//   remaining   in  CNT_WIDTH  beats still to issue (non-zero when used)
//   burst_beats out 9          1..256
// -----------------------------------------------------------------------------
module burst_len_calc
  import axi4_addr_issue_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic [11:0]          addr_lo,
  input  logic [2:0]           size,
  input  logic [CNT_WIDTH-1:0] remaining,
  output logic [8:0]           burst_beats
);
  // Common width wide enough for both the request count and the 13-bit cap.
  localparam int CW = (CNT_WIDTH > 13) ? CNT_WIDTH : 13;

  logic [11:0]   aligned_lo;
  logic [12:0]   to_4k;
  logic [12:0]   cap;
  logic [CW-1:0] rem_w;
  logic [CW-1:0] cap_w;
  logic [CW-1:0] pick;

  // NOTE: every variable is assigned on every pass through this block, so no
  // latch can be inferred; keep it that way when editing.
  always_comb begin
    aligned_lo  = addr_lo & ~((12'd1 << size) - 12'd1);
    // 4096 - aligned offset is 1..4096, hence 13 bits.
    to_4k       = (13'(BOUNDARY_4K) - {1'b0, aligned_lo}) >> size;
    cap         = (to_4k > 13'(MAX_BURST_BEATS)) ? 13'(MAX_BURST_BEATS) : to_4k;
    rem_w       = CW'(remaining);
    cap_w       = CW'(cap);
    pick        = (rem_w < cap_w) ? rem_w : cap_w;
    burst_beats = 9'(pick);
  end

endmodule

// File: rtl/axi4_addr_issue.sv
// -----------------------------------------------------------------------------
// axi4_addr_issue
// Splits a (start address, beat count, size) request into AXI4 INCR bursts
// that never exceed 256 beats and never cross a 4 KB boundary, issuing them
// one at a time on the AXI4 address channel.
// Ports:
//   aclk_i    in  rising-edge clock
//   areset_i  in  asynchronous, active-high reset
//   bus       slave modport of axi4_addr_issue_if (request handshake, AXI4
//             AxADDR/AxLEN/AxSIZE/AxBURST/AxVALID/AxREADY, busy_o, done_o)
// Timing: request accepted in cycle N -> axvalid_o in N+2; each further burst
// starts 2 cycles after the previous address handshake; done_o pulses the
// cycle after the last address handshake (or after acceptance for 0 beats).
// -----------------------------------------------------------------------------
module axi4_addr_issue
  import axi4_addr_issue_pkg::*;
#(
  parameter int ADDR_WIDTH = `AXI4_ADDR_WIDTH,
  parameter int CNT_WIDTH  = 16,
  parameter int MAX_SIZE   = 2
) (
  input  logic              aclk_i,
  input  logic              areset_i,
  axi4_addr_issue_if.slave  bus
);

  issue_state_t          state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [2:0]            size_q;
  logic [8:0]            burst_q;
  logic [8:0]            burst_calc;
  logic                  addr_hs;

  assign addr_hs = bus.axvalid_o & bus.axready_i;

  burst_len_calc #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_burst_len_calc (
    .addr_lo     (cur_addr[11:0]),
    .size        (size_q),
    .remaining   (remaining),
    .burst_beats (burst_calc)
  );

  // NOTE: all state, including every output register, lives in this one
  // block and uses non-blocking assignments, so every read sees the value
  // from before the edge regardless of statement order.
  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      state           <= IDLE;
      cur_addr        <= '0;
      remaining       <= '0;
      size_q          <= '0;
      burst_q         <= '0;
      bus.req_ready_o <= 1'b1;
      bus.busy_o      <= 1'b0;
      bus.done_o      <= 1'b0;
      bus.axvalid_o   <= 1'b0;
      bus.axaddr_o    <= '0;
      bus.axlen_o     <= '0;
      bus.axsize_o    <= '0;
      bus.axburst_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i && bus.req_ready_o) begin
            cur_addr        <= bus.req_addr_i;
            remaining       <= bus.req_beats_i;
            size_q          <= clamp_size(bus.req_size_i, 3'(MAX_SIZE));
            bus.req_ready_o <= 1'b0;
            bus.busy_o      <= 1'b1;
            if (bus.req_beats_i == '0) begin
              state      <= DONE;
              bus.done_o <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end

        // Latch the burst length and load the whole address beat at once so
        // the Ax* fields stay frozen for as long as axready_i is low.
        CALC: begin
          burst_q       <= burst_calc;
          bus.axaddr_o  <= cur_addr;
          bus.axlen_o   <= 8'(burst_calc - 9'd1);
          bus.axsize_o  <= size_q;
          bus.axburst_o <= BURST_INCR;
          bus.axvalid_o <= 1'b1;
          state         <= ISSUE;
        end

        ISSUE: begin
          if (addr_hs) begin
            bus.axvalid_o <= 1'b0;
            // Wraps modulo 2^ADDR_WIDTH by construction.
            cur_addr      <= cur_addr + (ADDR_WIDTH'(burst_q) << size_q);
            remaining     <= remaining - CNT_WIDTH'(burst_q);
            if (remaining == CNT_WIDTH'(burst_q)) begin
              state      <= DONE;
              bus.done_o <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end

        DONE: begin
          bus.done_o      <= 1'b0;
          bus.busy_o      <= 1'b0;
          bus.req_ready_o <= 1'b1;
          state           <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_addr_issue.sv
// -----------------------------------------------------------------------------
// tb_axi4_addr_issue
// Scoreboard bench for axi4_addr_issue. A driver issues directed and random
// requests; at each accepted request a behavioural model pushes the expected
// bursts and a completion marker into a queue. An independent monitor pops
// and compares on every address handshake and done_o pulse, and also checks
// busy/ready, launch latency and Ax* stability while stalled.
// -----------------------------------------------------------------------------
module tb_axi4_addr_issue;
  import axi4_addr_issue_pkg::*;

  localparam int AW = 32;
  localparam int CW = 16;
  localparam int MS = 2;

  logic aclk_i = 1'b0;
  logic areset_i;

  axi4_addr_issue_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus_if ();

  axi4_addr_issue #(
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW),
    .MAX_SIZE   (MS)
  ) dut (
    .aclk_i   (aclk_i),
    .areset_i (areset_i),
    .bus      (bus_if.slave)
  );

  initial forever #5 aclk_i = ~aclk_i;

  typedef struct {
    bit          is_done;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } exp_t;

  exp_t   exp_q[$];
  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;
  bit     force_low = 1'b0;

  always @(posedge aclk_i) cyc++;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: walk the request in byte-address space, cutting at
  // 256 beats and at each 4 KB boundary.
  function automatic void model_push(input logic [31:0] addr,
                                     input int unsigned beats,
                                     input logic [2:0] size);
    int unsigned s, rem, off, to4k, n;
    logic [31:0] a;
    exp_t e;
    s   = (int'(size) > MS) ? MS : int'(size);
    a   = addr;
    rem = beats;
    while (rem > 0) begin
      off  = ((a % 4096) >> s) << s;
      to4k = (4096 - off) >> s;
      n    = rem;
      if (n > 256)  n = 256;
      if (n > to4k) n = to4k;
      e.is_done = 1'b0;
      e.addr    = a;
      e.len     = 8'(n - 1);
      e.size    = 3'(s);
      exp_q.push_back(e);
      a   = a + 32'(n << s);
      rem = rem - n;
    end
    e.is_done = 1'b1;
    e.addr    = '0;
    e.len     = '0;
    e.size    = '0;
    exp_q.push_back(e);
  endfunction

  // ---------------------------------------------------------------- monitor
  longint      last_evt   = -100;
  bit          busy_exp   = 1'b0;
  bit          prev_valid = 1'b0;
  bit          prev_ready = 1'b0;
  bit          prev_done  = 1'b0;
  logic [31:0] prev_addr;
  logic [7:0]  prev_len;
  logic [2:0]  prev_size;
  logic [1:0]  prev_burst;

  always @(negedge aclk_i) begin
    if (areset_i) begin
      exp_q.delete();
      busy_exp   = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_done  = 1'b0;
      last_evt   = -100;
    end else begin
      check("busy_o", bus_if.busy_o, busy_exp);
      check("req_ready_o", bus_if.req_ready_o, !busy_exp);

      if (prev_valid && !prev_ready) begin
        check("hold_axvalid", bus_if.axvalid_o, 1'b1);
        check("hold_axaddr", bus_if.axaddr_o, prev_addr);
        check("hold_axlen", bus_if.axlen_o, prev_len);
        check("hold_axsize", bus_if.axsize_o, prev_size);
        check("hold_axburst", bus_if.axburst_o, prev_burst);
      end else if (bus_if.axvalid_o && !prev_valid) begin
        check("axvalid_latency", cyc, last_evt + 2);
        check("burst_pending_on_valid",
              exp_q.size() > 0 && !exp_q[0].is_done, 1'b1);
      end

      if (bus_if.axvalid_o && bus_if.axready_i) begin
        check("burst_expected", exp_q.size() > 0 && !exp_q[0].is_done, 1'b1);
        if (exp_q.size() > 0 && !exp_q[0].is_done) begin
          exp_t e;
          e = exp_q.pop_front();
          check("axaddr", bus_if.axaddr_o, e.addr);
          check("axlen", bus_if.axlen_o, e.len);
          check("axsize", bus_if.axsize_o, e.size);
          check("axburst", bus_if.axburst_o, 2'b01);
        end
        last_evt = cyc;
      end

      if (bus_if.done_o) begin
        check("done_single_cycle", prev_done, 1'b0);
        check("done_latency", cyc, last_evt + 1);
        check("done_expected", exp_q.size() > 0 && exp_q[0].is_done, 1'b1);
        if (exp_q.size() > 0 && exp_q[0].is_done) void'(exp_q.pop_front());
        busy_exp = 1'b0;
      end

      if (bus_if.req_valid_i && bus_if.req_ready_o) begin
        last_evt = cyc;
        busy_exp = 1'b1;
      end

      prev_valid = bus_if.axvalid_o;
      prev_ready = bus_if.axready_i;
      prev_done  = bus_if.done_o;
      prev_addr  = bus_if.axaddr_o;
      prev_len   = bus_if.axlen_o;
      prev_size  = bus_if.axsize_o;
      prev_burst = bus_if.axburst_o;
    end
  end

  // ------------------------------------------------------ AXI4 slave model
  initial begin
    bus_if.axready_i = 1'b0;
    forever begin
      @(posedge aclk_i);
      #1;
      bus_if.axready_i = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ------------------------------------------------------------- driver
  task automatic do_req(input logic [31:0] addr, input int unsigned beats,
                        input logic [2:0] size);
    int n = 0;
    @(posedge aclk_i);
    #1;
    bus_if.req_addr_i  = addr;
    bus_if.req_beats_i = 16'(beats);
    bus_if.req_size_i  = size;
    bus_if.req_valid_i = 1'b1;
    @(negedge aclk_i);
    while (!bus_if.req_ready_o && n < 3000) begin
      @(negedge aclk_i);
      n++;
    end
    check("req_accepted", bus_if.req_ready_o, 1'b1);
    if (bus_if.req_ready_o) model_push(addr, beats, size);
    @(posedge aclk_i);
    #1;
    bus_if.req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge aclk_i);
    while ((bus_if.busy_o || exp_q.size() != 0) && n < 5000) begin
      @(negedge aclk_i);
      n++;
    end
    check("drain_in_budget", n < 5000, 1'b1);
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge aclk_i);
    while (!bus_if.axvalid_o && n < 100) begin
      @(negedge aclk_i);
      n++;
    end
    check("axvalid_seen", bus_if.axvalid_o, 1'b1);
  endtask

  // --------------------------------------------------------------- main
  initial begin
    int stall_cnt;
    logic [31:0] ra;
    // NOTE: stimulus is driven with blocking assignments, #1 after the
    // rising edge, so the DUT never samples an input while it is changing.
    areset_i           = 1'b0;
    bus_if.req_valid_i = 1'b0;
    bus_if.req_addr_i  = '0;
    bus_if.req_beats_i = '0;
    bus_if.req_size_i  = '0;
    #1 areset_i = 1'b1;
    #1;
    check("rst_req_ready", bus_if.req_ready_o, 1'b1);
    check("rst_busy", bus_if.busy_o, 1'b0);
    check("rst_done", bus_if.done_o, 1'b0);
    check("rst_axvalid", bus_if.axvalid_o, 1'b0);
    check("rst_axaddr", bus_if.axaddr_o, 32'h0);
    check("rst_axlen", bus_if.axlen_o, 8'h0);
    check("rst_axsize", bus_if.axsize_o, 3'h0);
    check("rst_axburst", bus_if.axburst_o, 2'h0);
    repeat (2) @(posedge aclk_i);
    #1 areset_i = 1'b0;

    // Single aligned burst.
    do_req(32'h0000_0000, 16, 3'd2);
    wait_idle();
    // 4 KB split.
    do_req(32'h0000_0FF0, 8, 3'd2);
    wait_idle();
    // 256-beat split; requests presented while busy must be ignored.
    do_req(32'h0000_1000, 600, 3'd0);
    bus_if.req_valid_i = 1'b1;
    bus_if.req_addr_i  = 32'hDEAD_BEE0;
    bus_if.req_beats_i = 16'd5;
    repeat (6) @(posedge aclk_i);
    #1 bus_if.req_valid_i = 1'b0;
    wait_idle();
    // Oversized beat is clamped to the bus width.
    do_req(32'h0000_0040, 10, 3'd7);
    wait_idle();
    // Address wrap at the top of the address space.
    do_req(32'hFFFF_FFF0, 8, 3'd2);
    wait_idle();

    // Stall: axready_i low for 5 cycles while axvalid_o is up.
    force_low = 1'b1;
    do_req(32'h0000_3000, 4, 3'd2);
    wait_valid();
    stall_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk_i);
      if (bus_if.axvalid_o && !bus_if.axready_i) stall_cnt++;
    end
    check("stall_cycles", stall_cnt, 5);
    force_low = 1'b0;
    wait_idle();

    // Empty request.
    do_req(32'h0000_0055, 0, 3'd2);
    wait_idle();

    // Reset during ISSUE.
    force_low = 1'b1;
    do_req(32'h0000_2000, 32, 3'd2);
    wait_valid();
    @(posedge aclk_i);
    #2 areset_i = 1'b1;
    #1;
    check("midrst_axvalid", bus_if.axvalid_o, 1'b0);
    check("midrst_busy", bus_if.busy_o, 1'b0);
    check("midrst_done", bus_if.done_o, 1'b0);
    check("midrst_req_ready", bus_if.req_ready_o, 1'b1);
    @(negedge aclk_i);
    check("midrst_done_held", bus_if.done_o, 1'b0);
    @(posedge aclk_i);
    #1 areset_i = 1'b0;
    force_low = 1'b0;
    do_req(32'h0000_2000, 32, 3'd2);
    wait_idle();

    // Random requests, biased towards 4 KB edges and the address-space top.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 2))
        0:       ra = $urandom;
        1:       ra = ($urandom & 32'hFFFF_F000) | (32'h0000_1000 - 32'($urandom_range(1, 64)));
        default: ra = 32'hFFFF_F000 | 32'($urandom_range(0, 4095));
      endcase
      do_req(ra, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : $urandom_range(1, 700),
             3'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
